// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return-address stack for the FRANK6000 core.
// The control-bus return field arrives on port `ret`; every redirect is followed by one flush bubble.
module pc_sequencer #(
    parameter int                ADDR_W       = 10,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               jump,
    input  logic [1:0]                         j_mode,
    input  logic                               call,
    input  logic                               ret,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               zero_flag,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               flush,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_ptr,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err,
    output logic [1:0]                         state_dbg
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO  = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              flush_q, err_q;
    logic              push;
    logic              full, empty;
    logic [ADDR_W-1:0] pc_inc, pc_inc2, tos;
    logic [SP_W-1:0]   top_ptr;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    // Natural overflow of the ADDR_W-bit adders gives the required wrap-around.
    assign pc_inc  = pc_q + PC_ONE;
    assign pc_inc2 = pc_q + PC_TWO;
    assign full    = (sp_q == SP_FULL);
    assign empty   = (sp_q == '0);
    assign top_ptr = sp_q - 1'b1;
    assign tos     = stack_mem[top_ptr[IDX_W-1:0]];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        if (en) begin
            case (state_q)
                S_RUN: begin
                    if (call && ret) begin
                        state_d = S_FAULT;
                    end else if (j_mode == 2'b10 && jump) begin
                        if (call && full) begin
                            state_d = S_FAULT;
                        end else begin
                            pc_d    = target;
                            state_d = S_FLUSH;
                            if (call) begin
                                push = 1'b1;
                                sp_d = sp_q + 1'b1;
                            end
                        end
                    end else if (j_mode == 2'b11 && ret) begin
                        if (empty) begin
                            state_d = S_FAULT;
                        end else begin
                            pc_d    = tos;
                            sp_d    = top_ptr;
                            state_d = S_FLUSH;
                        end
                    end else if (j_mode == 2'b00 && zero_flag) begin
                        pc_d    = pc_inc2;
                        state_d = S_FLUSH;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                // Control inputs here belong to the discarded instruction.
                S_FLUSH: begin
                    pc_d    = pc_inc;
                    state_d = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VECTOR;
            sp_q    <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            flush_q <= (state_d == S_FLUSH);
            err_q   <= (state_d == S_FAULT);
        end
    end

    // Stack storage carries no reset; only entries below stack_ptr are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp_q[IDX_W-1:0]] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign stack_ptr   = sp_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer: a queue-based stack model predicts every
// enabled/disabled cycle and a monitor compares the DUT after each rising edge.
module tb_pc_sequencer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 8;
    localparam int SP_W   = 4;
    localparam int W      = 2 + ADDR_W + 1 + SP_W + 3;
    localparam int PC_MOD = 1 << ADDR_W;

    logic              clk;
    logic              rst_n     = 1'b0;
    logic              en        = 1'b0;
    logic              jump      = 1'b0;
    logic [1:0]        j_mode    = 2'b01;
    logic              call      = 1'b0;
    logic              ret       = 1'b0;
    logic [ADDR_W-1:0] target    = '0;
    logic              zero_flag = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic [SP_W-1:0]   stack_ptr;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;
    logic [1:0]        state_dbg;

    pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .j_mode(j_mode),
        .call(call), .ret(ret), .target(target), .zero_flag(zero_flag),
        .pc(pc), .flush(flush), .stack_ptr(stack_ptr), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: mode 0 = running, 1 = bubble, 2 = faulted
    int m_pc;
    int m_mode;
    int m_stack[$];

    function automatic logic [W-1:0] model_vec();
        int sp;
        sp = m_stack.size();
        return {2'(m_mode), ADDR_W'(m_pc), m_mode == 1, SP_W'(sp), sp == DEPTH, sp == 0, m_mode == 2};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {state_dbg, pc, flush, stack_ptr, stack_full, stack_empty, stack_err};
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s t=%0t got{st,pc,fl,sp,fu,em,er}=%h pc=%0d sp=%0d required=%h pc=%0d sp=%0d",
                     name, $time, got, got[W-3 -: ADDR_W], got[6:3], expv, expv[W-3 -: ADDR_W], expv[6:3]);
        end
    endtask

    task automatic model_step(input logic e, input logic j, input logic [1:0] jm,
                              input logic c, input logic r, input logic [ADDR_W-1:0] t,
                              input logic z);
        if (!e) return;
        if (m_mode == 1) begin
            m_pc   = (m_pc + 1) % PC_MOD;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (c && r) begin
                m_mode = 2;
            end else if (jm == 2'b10 && j) begin
                if (c && m_stack.size() == DEPTH) begin
                    m_mode = 2;
                end else begin
                    if (c) m_stack.push_back((m_pc + 1) % PC_MOD);
                    m_pc   = int'(t);
                    m_mode = 1;
                end
            end else if (jm == 2'b11 && r) begin
                if (m_stack.size() == 0) begin
                    m_mode = 2;
                end else begin
                    m_pc   = m_stack.pop_back();
                    m_mode = 1;
                end
            end else if (jm == 2'b00 && z) begin
                m_pc   = (m_pc + 2) % PC_MOD;
                m_mode = 1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    // Monitor: one expectation per clock after stimulus was issued
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) check_vec("step", dut_vec(), exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic step(input logic e, input logic j, input logic [1:0] jm, input logic c,
                        input logic r, input logic [ADDR_W-1:0] t, input logic z);
        @(negedge clk);
        en = e; jump = j; j_mode = jm; call = c; ret = r; target = t; zero_flag = z;
        model_step(e, j, jm, c, r, t, z);
        exp_q.push_back(model_vec());
    endtask

    task automatic inc();
        step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic jmp(input int t, input logic c);
        step(1'b1, 1'b1, 2'b10, c, 1'b0, ADDR_W'(t), 1'b0);
    endtask

    task automatic retn();
        step(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic skip(input logic z);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0, z);
    endtask

    task automatic rnd_step(input logic e);
        step(e, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             ADDR_W'($urandom_range(0, PC_MOD - 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Reset lands between clock edges and is checked before the next rising edge.
    task automatic do_reset();
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0; jump = 1'b0; j_mode = 2'b01; call = 1'b0; ret = 1'b0; zero_flag = 1'b0;
        m_pc   = 0;
        m_mode = 0;
        m_stack.delete();
        #1;
        check_vec("async_reset", dut_vec(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Sequential fetch 1..5
        repeat (5) inc();

        // Call/return round trip
        jmp(10'h100, 1'b1);
        rnd_step(1'b1);
        inc();
        retn();
        rnd_step(1'b1);

        // Skip taken and not taken at pc=20
        jmp(19, 1'b0);
        rnd_step(1'b1);
        skip(1'b1);
        rnd_step(1'b1);
        jmp(19, 1'b0);
        rnd_step(1'b1);
        skip(1'b0);

        // Stall inside the bubble
        jmp(300, 1'b0);
        repeat (3) rnd_step(1'b0);
        rnd_step(1'b1);
        inc();

        // Wrap-around of increment, skip and pushed return address
        jmp(PC_MOD - 3, 1'b0);
        rnd_step(1'b1);
        inc();
        inc();
        jmp(PC_MOD - 3, 1'b0);
        rnd_step(1'b1);
        skip(1'b1);
        rnd_step(1'b1);
        jmp(PC_MOD - 2, 1'b0);
        rnd_step(1'b1);
        jmp(50, 1'b1);
        rnd_step(1'b1);
        retn();
        rnd_step(1'b1);

        // Overflow: eight nested calls then a ninth
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            jmp(100 + i * 10, 1'b1);
            rnd_step(1'b1);
        end
        jmp(500, 1'b1);
        for (int i = 0; i < 6; i++) rnd_step(1'($urandom_range(0, 1)));

        // Underflow
        do_reset();
        inc();
        inc();
        retn();
        for (int i = 0; i < 4; i++) rnd_step(1'($urandom_range(0, 1)));

        // Random traffic, recovering from faults with a reset
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2 && $urandom_range(0, 2) == 0) do_reset();
            else rnd_step($urandom_range(0, 7) != 0);
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer and hardware call/return stack for the FRANK6000 core.
- Consumes the jump/j_mode/call/return fields of the control bus each instruction and produces the fetch address.
- Owns the return-address stack and inserts a one-cycle flush bubble after every redirect.
- Sits between instruction decode and program memory.

Parameters:
- ADDR_W, 10, width of program counter, branch target and stack entries.
- STACK_DEPTH, 8, number of return-address entries (>=2).
- RESET_VECTOR, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  advance enable; 0 freezes all state
- jump  input  1  control bus: unconditional redirect request
- j_mode  input  2  control bus: next-PC mode (00 skip-if-zero, 01 increment, 10 target, 11 stack top)
- call  input  1  control bus: push return address on redirect
- return  input  1  control bus: pop return address
- target  input  ADDR_W  branch/call target from instruction literal
- zero_flag  input  1  STATUS zero bit, used by skip mode
- pc  output  ADDR_W  current fetch address (registered)
- flush  output  1  current fetched instruction is a bubble; decode must suppress writes
- stack_ptr  output  $clog2(STACK_DEPTH+1)  number of valid stack entries
- stack_full  output  1  stack_ptr == STACK_DEPTH
- stack_empty  output  1  stack_ptr == 0
- stack_err  output  1  sticky fault flag

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_VECTOR, stack_ptr=0, state=S_RUN, flush=0, stack_err=0.
  - Stack RAM contents are don't-care.
- Reset asserted mid-operation aborts any redirect or flush immediately. No stack contents survive.
- en=0: pc, stack, state and all outputs hold. Control inputs are ignored that cycle.
- FSM states: S_RUN, S_FLUSH, S_FAULT. flush=1 iff state==S_FLUSH. stack_err=1 iff state==S_FAULT.
- S_RUN, evaluated on each enabled edge:
  - Illegal combination (call=1 and return=1): go to S_FAULT, pc holds.
  - j_mode=01, or j_mode=10 with jump=0, or j_mode=11 with return=0:
    - pc<=pc+1, stay in S_RUN.
    - call is ignored.
  - j_mode=10 and jump=1:
    - pc<=target, go to S_FLUSH.
    - If call=1, push pc+1 and increment stack_ptr.
    - If call=1 and stack_full, no push: go to S_FAULT, pc holds.
  - j_mode=11 and return=1:
    - If stack_empty: go to S_FAULT, pc holds.
    - Otherwise pc<=top entry, decrement stack_ptr, go to S_FLUSH.
  - j_mode=00:
    - zero_flag=1: pc<=pc+2, go to S_FLUSH.
    - zero_flag=0: pc<=pc+1, stay in S_RUN.
- S_FLUSH: control inputs belong to the discarded instruction and are ignored. pc<=pc+1, go to S_RUN. Exactly one bubble per redirect.
- S_FAULT: pc, stack and stack_ptr are frozen. Only rst_n exits.
- PC arithmetic is modulo 2^ADDR_W:
  - pc+1 at all-ones wraps to 0.
  - pc+2 at all-ones-1 wraps to 0.
  - Pushed pc+1 wraps the same way.
- Push and pop never occur in the same cycle. The top-of-stack read is combinational from entry stack_ptr-1.
- stack_full and stack_empty are derived from the registered stack_ptr and update in the cycle after a push or pop.

Test Plan:
- Reset/sequential:
  - Hold rst_n=0, then release with j_mode=01 and en=1 for 5 cycles -> pc = 0,1,2,3,4,5, flush=0 throughout.
  - Force pc near 1023 and keep incrementing -> wraps to 0.
- Call/return round trip:
  - At pc=5, drive jump=1, j_mode=10, call=1, target=0x100 -> pc=0x100, flush=1 for one cycle, stack_ptr=1.
  - Then increment to 0x102 and drive j_mode=11, return=1 -> pc=6, flush=1 for one cycle, stack_ptr=0.
- Overflow:
  - 8 nested calls -> stack_full=1.
  - A 9th call -> stack_err=1 and pc frozen at the 9th call address; en and control changes have no effect until rst_n.
- Underflow: return with stack_ptr=0 -> stack_err=1, pc held.
- Skip:
  - j_mode=00 at pc=20 with zero_flag=1 -> pc=22, flush=1 for one cycle.
  - Same with zero_flag=0 -> pc=21, no flush.
- Stall and async reset:
  - Deassert en during S_FLUSH for 3 cycles -> flush stays 1 and pc holds. On re-enable, pc+1 and flush=0.
  - Assert rst_n=0 mid-cycle -> pc=RESET_VECTOR immediately, without waiting for a clock edge.
